// File: rtl/sw_job_scheduler_if.sv
// Host-side command and result channels of the multi-core Smith-Waterman job scheduler.
// The host drives the master modport; the scheduler implements the slave modport.
interface sw_job_scheduler_if #(
    parameter int CORE_W  = 1,
    parameter int SCORE_W = 12
);
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic               i_cmd_op;
    logic [CORE_W-1:0]  i_cmd_core;
    logic               o_cmd_err;
    logic               o_res_valid;
    logic [CORE_W-1:0]  o_res_core;
    logic [SCORE_W-1:0] o_res_score;
    logic               o_res_lost;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_core,
        input  o_cmd_ready, o_cmd_err, o_res_valid, o_res_core, o_res_score, o_res_lost
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_core,
        output o_cmd_ready, o_cmd_err, o_res_valid, o_res_core, o_res_score, o_res_lost
    );
endinterface

// File: rtl/sw_job_scheduler.sv
// Multi-core Smith-Waterman job scheduler: command steering, scoring parameters, result serialiser.
// Optional running-best tracking is enabled by defining SW_BEST_TRACK_EN.
module sw_job_scheduler #(
    parameter int N_CORE  = 2,
    parameter int CORE_W  = 1,
    parameter int SCORE_W = 12,
    parameter int MATCH_W = 4,
    parameter int GAP_W   = 4,
    parameter int TSZ_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sw_job_scheduler_if.slave         host,
    input  logic [MATCH_W-1:0]        i_match,
    input  logic [MATCH_W-1:0]        i_mismatch,
    input  logic [GAP_W-1:0]          i_minus_alpha,
    input  logic [GAP_W-1:0]          i_minus_beta,
    output logic [MATCH_W-1:0]        o_match,
    output logic [SCORE_W-1:0]        o_mismatch,
    output logic [SCORE_W-1:0]        o_alpha,
    output logic [SCORE_W-1:0]        o_beta,
    output logic [N_CORE-1:0]         o_start_read_t,
    output logic [N_CORE-1:0]         o_start_cal,
    input  logic [N_CORE-1:0]         i_sram_busy,
    input  logic [N_CORE-1:0]         i_dp_busy,
    input  logic [N_CORE*TSZ_W-1:0]   i_t_size,
    input  logic [N_CORE-1:0]         i_core_valid,
    input  logic [N_CORE*SCORE_W-1:0] i_core_result,
    output logic                      o_busy,
    output logic [SCORE_W-1:0]        o_best_score,
    output logic [CORE_W-1:0]         o_best_core
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETT  = 2'd1,
        ST_CALC  = 2'd2,
        ST_RESET = 2'd3
    } core_state_t;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [31:0]       cmd_core_ext;
    logic              cmd_idx_ok;
    logic              cmd_ready;
    logic              cmd_tsize_zero;
    logic              cmd_accept;
    logic              sett_go;
    logic              calc_go;
    logic              calc_reject;
    logic              idx_reject;
    logic [N_CORE-1:0] cmd_sel;
    logic [N_CORE-1:0] core_idle;
    logic [N_CORE-1:0] core_in_calc;
    logic              cmd_err_reg;
    logic              busy_reg;

    // Index widened to 32 bits so an out-of-range core number is detectable for any CORE_W.
    always_comb begin
        cmd_core_ext   = 32'(host.i_cmd_core);
        cmd_idx_ok     = (cmd_core_ext < 32'(N_CORE));
        cmd_sel        = '0;
        cmd_ready      = 1'b0;
        cmd_tsize_zero = 1'b0;
        for (int k = 0; k < N_CORE; k++) begin
            if (cmd_idx_ok && (cmd_core_ext == 32'(k))) begin
                cmd_sel[k]     = 1'b1;
                cmd_ready      = core_idle[k];
                cmd_tsize_zero = (i_t_size[k*TSZ_W +: TSZ_W] == '0);
            end
        end
    end

    assign host.o_cmd_ready = cmd_ready;
    assign cmd_accept       = host.i_cmd_valid & cmd_ready;
    assign sett_go          = cmd_accept & ~host.i_cmd_op;
    assign calc_go          = cmd_accept & host.i_cmd_op & ~cmd_tsize_zero;
    assign calc_reject      = cmd_accept & host.i_cmd_op & cmd_tsize_zero;
    assign idx_reject       = host.i_cmd_valid & ~cmd_idx_ok;

    // ------------------------------------------------------------------
    // Per-core control FSMs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CORE; gi++) begin : g_core
        core_state_t state_reg;
        core_state_t state_next;
        logic        start_read_t_reg;
        logic        start_read_t_next;
        logic        start_cal_reg;
        logic        start_cal_next;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg        <= ST_IDLE;
                start_read_t_reg <= 1'b0;
                start_cal_reg    <= 1'b0;
            end else begin
                state_reg        <= state_next;
                start_read_t_reg <= start_read_t_next;
                start_cal_reg    <= start_cal_next;
            end
        end

        // SETT waits out its own start pulse so a slow SRAM busy cannot be missed.
        always_comb begin
            state_next        = state_reg;
            start_read_t_next = 1'b0;
            start_cal_next    = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_sel[gi]) begin
                        if (sett_go) begin
                            state_next        = ST_SETT;
                            start_read_t_next = 1'b1;
                        end else if (calc_go) begin
                            state_next     = ST_CALC;
                            start_cal_next = 1'b1;
                        end
                    end
                end
                ST_SETT: begin
                    if (!i_sram_busy[gi] && !start_read_t_reg)
                        state_next = ST_IDLE;
                end
                ST_CALC: begin
                    if (i_core_valid[gi])
                        state_next = ST_RESET;
                end
                ST_RESET: begin
                    if (!i_sram_busy[gi] && !i_dp_busy[gi])
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end

        assign core_idle[gi]      = (state_reg == ST_IDLE);
        assign core_in_calc[gi]   = (state_reg == ST_CALC);
        assign o_start_read_t[gi] = start_read_t_reg;
        assign o_start_cal[gi]    = start_cal_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            cmd_err_reg <= idx_reject | calc_reject;
            busy_reg    <= ~(&core_idle);
        end
    end

    assign host.o_cmd_err = cmd_err_reg;
    assign o_busy         = busy_reg;

    // ------------------------------------------------------------------
    // Scoring parameters: track the host while no core is calculating
    // ------------------------------------------------------------------
    logic [MATCH_W-1:0] match_reg;
    logic [SCORE_W-1:0] mismatch_reg;
    logic [SCORE_W-1:0] alpha_reg;
    logic [SCORE_W-1:0] beta_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_reg    <= MATCH_W'(6);
            mismatch_reg <= '1;
            alpha_reg    <= SCORE_W'(0) - SCORE_W'(2);
            beta_reg     <= '1;
        end else if (!(|core_in_calc)) begin
            match_reg    <= i_match;
            mismatch_reg <= SCORE_W'(0) - SCORE_W'(i_mismatch);
            alpha_reg    <= SCORE_W'(0) - SCORE_W'(i_minus_alpha);
            beta_reg     <= SCORE_W'(0) - SCORE_W'(i_minus_beta);
        end
    end

    assign o_match    = match_reg;
    assign o_mismatch = mismatch_reg;
    assign o_alpha    = alpha_reg;
    assign o_beta     = beta_reg;

    // ------------------------------------------------------------------
    // Result serialiser: one-deep slot per core, lowest index wins
    // ------------------------------------------------------------------
    logic [N_CORE-1:0]         pend_valid;
    logic [N_CORE*SCORE_W-1:0] pend_score;
    logic [N_CORE-1:0]         res_cand;
    logic [N_CORE-1:0]         emit_sel;
    logic                      emit_any;
    logic [CORE_W-1:0]         emit_core;
    logic [SCORE_W-1:0]        emit_score;
    logic                      lost_any;
    logic                      res_valid_reg;
    logic [CORE_W-1:0]         res_core_reg;
    logic [SCORE_W-1:0]        res_score_reg;
    logic                      res_lost_reg;

    // An incoming strobe into an empty slot is a candidate too, giving one-cycle latency.
    always_comb begin
        res_cand   = pend_valid | i_core_valid;
        emit_sel   = '0;
        emit_any   = 1'b0;
        emit_core  = '0;
        emit_score = '0;
        for (int k = N_CORE - 1; k >= 0; k--) begin
            if (res_cand[k]) begin
                emit_sel    = '0;
                emit_sel[k] = 1'b1;
                emit_any    = 1'b1;
                emit_core   = CORE_W'(k);
                emit_score  = pend_valid[k] ? pend_score[k*SCORE_W +: SCORE_W]
                                            : i_core_result[k*SCORE_W +: SCORE_W];
            end
        end
        lost_any = |(pend_valid & i_core_valid & ~emit_sel);
    end

    // Slots latch regardless of FSM state; only the FSM ignores stray strobes.
    for (genvar gi = 0; gi < N_CORE; gi++) begin : g_slot
        logic               slot_valid_reg;
        logic [SCORE_W-1:0] slot_score_reg;
        logic               bypass;

        assign bypass = emit_sel[gi] & ~slot_valid_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_valid_reg <= 1'b0;
                slot_score_reg <= '0;
            end else if (i_core_valid[gi] && !bypass) begin
                slot_valid_reg <= 1'b1;
                slot_score_reg <= i_core_result[gi*SCORE_W +: SCORE_W];
            end else if (emit_sel[gi]) begin
                slot_valid_reg <= 1'b0;
            end
        end

        assign pend_valid[gi]                    = slot_valid_reg;
        assign pend_score[gi*SCORE_W +: SCORE_W] = slot_score_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_core_reg  <= '0;
            res_score_reg <= '0;
            res_lost_reg  <= 1'b0;
        end else begin
            res_valid_reg <= emit_any;
            res_lost_reg  <= lost_any;
            if (emit_any) begin
                res_core_reg  <= emit_core;
                res_score_reg <= emit_score;
            end
        end
    end

    assign host.o_res_valid = res_valid_reg;
    assign host.o_res_core  = res_core_reg;
    assign host.o_res_score = res_score_reg;
    assign host.o_res_lost  = res_lost_reg;

    // ------------------------------------------------------------------
    // Running best score
    // ------------------------------------------------------------------
`ifdef SW_BEST_TRACK_EN
    localparam logic [SCORE_W-1:0] SCORE_MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    logic [SCORE_W-1:0] best_score_reg;
    logic [CORE_W-1:0]  best_core_reg;

    // Strict greater-than keeps the earliest core on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score_reg <= SCORE_MOST_NEG;
            best_core_reg  <= '0;
        end else if (sett_go) begin
            best_score_reg <= SCORE_MOST_NEG;
            best_core_reg  <= '0;
        end else if (res_valid_reg && ($signed(res_score_reg) > $signed(best_score_reg))) begin
            best_score_reg <= res_score_reg;
            best_core_reg  <= res_core_reg;
        end
    end

    assign o_best_score = best_score_reg;
    assign o_best_core  = best_core_reg;
`else
    assign o_best_score = '0;
    assign o_best_core  = '0;
`endif

endmodule
